// File: rtl/vrased_viol_logger_if.sv
`default_nettype none
// ============================================================================
// Module      : vrased_viol_logger_if
// Description : Bundles the signals of the violation logger, apart from clock
//               and reset: monitor strobes, bus snapshot inputs, log
//               clear/pop controls, the core reset request and the log read
//               side.
//   master : drives src_viol, pc, data_addr, data_en, data_wr, dma_addr,
//            dma_en, clr_log, rd_en; observes reset, viol_cause, log_*.
//   slave  : the logger itself (the reverse directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface vrased_viol_logger_if #(
    parameter int N_SRC  = 6,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16
);
    localparam int c_entry_w = N_SRC + 3*ADDR_W + 3;
    localparam int c_cnt_w   = $clog2(DEPTH) + 1;

    logic [N_SRC-1:0]     src_viol;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    data_addr;
    logic                 data_en;
    logic                 data_wr;
    logic [ADDR_W-1:0]    dma_addr;
    logic                 dma_en;
    logic                 clr_log;
    logic                 rd_en;
    logic                 reset;
    logic [N_SRC-1:0]     viol_cause;
    logic                 log_valid;
    logic [c_entry_w-1:0] log_data;
    logic [c_cnt_w-1:0]   log_count;
    logic                 log_overflow;

    modport master (
        output src_viol, pc, data_addr, data_en, data_wr, dma_addr, dma_en,
               clr_log, rd_en,
        input  reset, viol_cause, log_valid, log_data, log_count, log_overflow
    );

    modport slave (
        input  src_viol, pc, data_addr, data_en, data_wr, dma_addr, dma_en,
               clr_log, rd_en,
        output reset, viol_cause, log_valid, log_data, log_count, log_overflow
    );
endinterface
`default_nettype wire

// File: rtl/vrased_viol_logger.sv
`default_nettype none
// ============================================================================
// Module      : vrased_viol_logger
// Description : Aggregates N_SRC monitor violation strobes into a stretched,
//               episode-based reset for the core, and logs one snapshot per
//               episode into a first-word-fall-through FIFO.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : vrased_viol_logger_if.slave (strobes, bus snapshot, clr_log,
//              rd_en in; reset, viol_cause, log_valid/data/count/overflow out)
//   Entry layout (MSB..LSB): {src_viol, pc, data_addr, dma_addr,
//                             data_en, data_wr, dma_en}
// Revision    : 1.0 - initial release
// ============================================================================
module vrased_viol_logger #(
    parameter int N_SRC      = 6,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    vrased_viol_logger_if.slave  bus
);
    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_entry_w = N_SRC + 3*ADDR_W + 3;
    localparam int c_str_w   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_str_w-1:0] c_str_load = c_str_w'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_str_w-1:0]   r_stretch, w_stretch_nxt;
    logic                 r_reset;
    logic                 w_detect;
    logic                 w_any;
    logic [N_SRC-1:0]     r_cause;
    logic                 r_overflow;
    logic [c_cnt_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_empty, w_full;
    logic                 w_push, w_pop, w_write, w_drop;
    logic [c_entry_w-1:0] w_entry;
    logic [c_entry_w-1:0] r_mem [DEPTH];

    assign w_any = |bus.src_viol;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_stretch_nxt = r_stretch;
        w_detect      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_detect      = 1'b1;
                    w_stretch_nxt = c_str_load;
                    // A one-cycle stretch is already satisfied by the first
                    // reset cycle, so go straight to waiting for quiet.
                    w_state_nxt   = (RST_CYCLES == 1) ? ST_HOLD : ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // Move to HOLD on the edge where the count reaches zero so the
                // reset is high for exactly RST_CYCLES cycles when the source
                // has already gone quiet.
                if ((r_stretch == '0) || (r_stretch == c_str_w'(1))) begin
                    w_stretch_nxt = '0;
                    w_state_nxt   = ST_HOLD;
                end else begin
                    w_stretch_nxt = r_stretch - c_str_w'(1);
                end
            end
            ST_HOLD: begin
                if (!w_any) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_stretch <= '0;
            r_reset   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_stretch <= w_stretch_nxt;
            r_reset   <= (w_state_nxt != ST_IDLE);
        end
    end

    // --------------------------------------------------------------- FIFO
    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == c_cnt_w'(DEPTH));

    assign w_entry = {bus.src_viol, bus.pc, bus.data_addr, bus.dma_addr,
                      bus.data_en, bus.data_wr, bus.dma_en};

    assign w_push  = w_detect && !bus.clr_log;
    assign w_pop   = bus.rd_en && !w_empty && !bus.clr_log;
    // When full, a simultaneous pop frees the head slot that the push reuses.
    assign w_write = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_cause    <= '0;
        end else if (bus.clr_log) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_cause    <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + c_cnt_w'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + c_cnt_w'(1);
            if (w_drop)  r_overflow <= 1'b1;
            r_cause <= r_cause | bus.src_viol;
        end
    end

    // Storage needs no reset: it is only visible through a non-empty head.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr[c_ptr_w-1:0]] <= w_entry;
    end

    assign bus.reset        = r_reset;
    assign bus.viol_cause   = r_cause;
    assign bus.log_overflow = r_overflow;
    assign bus.log_count    = w_count;
    assign bus.log_valid    = !w_empty;
    assign bus.log_data     = w_empty ? '0 : r_mem[r_rd_ptr[c_ptr_w-1:0]];
endmodule
`default_nettype wire

// File: tb/tb_vrased_viol_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrased_viol_logger
// Description : Directed self-checking bench for vrased_viol_logger with
//               N_SRC=6, ADDR_W=16, DEPTH=4, RST_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrased_viol_logger;
    localparam int c_pc_lsb = 3 + 2*16;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_chk;
    int   hi;

    vrased_viol_logger_if #(.N_SRC(6), .ADDR_W(16), .DEPTH(4)) bus ();

    vrased_viol_logger #(.N_SRC(6), .ADDR_W(16), .DEPTH(4), .RST_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until reset falls; n = number of cycles reset stayed high.
    task automatic run_out(output int n);
        n = 0;
        for (int i = 0; i < 50 && bus.reset; i++) begin
            tick();
            n++;
        end
        chk("reset_timeout", {63'd0, bus.reset}, 64'd0);
    endtask

    task automatic episode(input logic [15:0] pc_v, input logic rd);
        int n;
        bus.src_viol = 6'b000001;
        bus.pc       = pc_v;
        bus.rd_en    = rd;
        tick();
        bus.src_viol = '0;
        bus.rd_en    = 1'b0;
        run_out(n);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic clear();
        bus.clr_log = 1'b1;
        tick();
        bus.clr_log = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        reset_n       = 1'b0;
        bus.src_viol  = '0;
        bus.pc        = '0;
        bus.data_addr = '0;
        bus.data_en   = 1'b0;
        bus.data_wr   = 1'b0;
        bus.dma_addr  = '0;
        bus.dma_en    = 1'b0;
        bus.clr_log   = 1'b0;
        bus.rd_en     = 1'b0;
        repeat (3) tick();
        chk("rst_reset",    {63'd0, bus.reset},        64'd0);
        chk("rst_cause",    {58'd0, bus.viol_cause},   64'd0);
        chk("rst_valid",    {63'd0, bus.log_valid},    64'd0);
        chk("rst_count",    {61'd0, bus.log_count},    64'd0);
        chk("rst_overflow", {63'd0, bus.log_overflow}, 64'd0);
        chk("rst_data",     {7'd0, bus.log_data},      64'd0);
        reset_n = 1'b1;
        tick();

        // 1: single-cycle violation, 4-cycle stretch, entry capture
        bus.src_viol  = 6'b000100;
        bus.pc        = 16'hA010;
        bus.data_addr = 16'h6A04;
        bus.dma_addr  = 16'h1234;
        bus.data_en   = 1'b1;
        bus.data_wr   = 1'b0;
        bus.dma_en    = 1'b1;
        chk("s1_pre_reset", {63'd0, bus.reset}, 64'd0);
        tick();
        chk("s1_reset_up", {63'd0, bus.reset}, 64'd1);
        chk("s1_valid", {63'd0, bus.log_valid}, 64'd1);
        chk("s1_data", {7'd0, bus.log_data},
            {7'd0, 6'b000100, 16'hA010, 16'h6A04, 16'h1234, 3'b101});
        chk("s1_cause", {58'd0, bus.viol_cause}, 64'd4);
        bus.src_viol = '0;
        bus.data_en  = 1'b0;
        bus.dma_en   = 1'b0;
        run_out(hi);
        chk("s1_reset_len", hi, 4);
        chk("s1_count", {61'd0, bus.log_count}, 64'd1);
        pop();
        chk("s1_pop_valid", {63'd0, bus.log_valid}, 64'd0);
        chk("s1_pop_data", {7'd0, bus.log_data}, 64'd0);
        pop();
        chk("s1_underflow", {61'd0, bus.log_count}, 64'd0);

        // 2: held violation stretches reset until one cycle after it clears
        bus.src_viol = 6'b000001;
        bus.pc       = 16'hB000;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.reset) hi++;
            bus.pc = 16'hB001;
        end
        bus.src_viol = '0;
        begin
            int n;
            run_out(n);
            hi += n;
        end
        chk("s2_reset_len", hi, 11);
        chk("s2_count", {61'd0, bus.log_count}, 64'd1);
        chk("s2_pc", {48'd0, bus.log_data[c_pc_lsb +: 16]}, 64'hB000);
        clear();
        chk("s2_clr_count", {61'd0, bus.log_count}, 64'd0);
        chk("s2_clr_cause", {58'd0, bus.viol_cause}, 64'd0);

        // 3: a second source during ASSERT is only OR'd into the cause
        bus.src_viol = 6'b000001;
        tick();
        bus.src_viol = 6'b100000;
        tick();
        bus.src_viol = '0;
        run_out(hi);
        chk("s3_cause", {58'd0, bus.viol_cause}, 64'h21);
        chk("s3_count", {61'd0, bus.log_count}, 64'd1);
        clear();

        // 4: five episodes into a 4-deep FIFO
        for (int i = 0; i < 5; i++) episode(16'h1000 + 16'(i), 1'b0);
        chk("s4_count", {61'd0, bus.log_count}, 64'd4);
        chk("s4_overflow", {63'd0, bus.log_overflow}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("s4_order", {48'd0, bus.log_data[c_pc_lsb +: 16]}, 64'h1000 + 64'(i));
            pop();
        end
        chk("s4_empty", {63'd0, bus.log_valid}, 64'd0);
        chk("s4_ovf_sticky", {63'd0, bus.log_overflow}, 64'd1);
        clear();
        chk("s4_ovf_clr", {63'd0, bus.log_overflow}, 64'd0);

        // 5: push and pop together while full
        for (int i = 0; i < 4; i++) episode(16'h2000 + 16'(i), 1'b0);
        chk("s5_full", {61'd0, bus.log_count}, 64'd4);
        episode(16'h2004, 1'b1);
        chk("s5_count", {61'd0, bus.log_count}, 64'd4);
        chk("s5_overflow", {63'd0, bus.log_overflow}, 64'd0);
        chk("s5_head", {48'd0, bus.log_data[c_pc_lsb +: 16]}, 64'h2001);
        repeat (3) pop();
        chk("s5_tail", {48'd0, bus.log_data[c_pc_lsb +: 16]}, 64'h2004);
        clear();

        // 6a: clr_log coinciding with a detection
        bus.src_viol = 6'b000010;
        bus.clr_log  = 1'b1;
        tick();
        bus.src_viol = '0;
        bus.clr_log  = 1'b0;
        chk("s6_clr_count", {61'd0, bus.log_count}, 64'd0);
        chk("s6_clr_cause", {58'd0, bus.viol_cause}, 64'd0);
        run_out(hi);
        chk("s6_clr_reset_len", hi, 4);

        // 6b: asynchronous reset in the middle of ASSERT
        bus.src_viol = 6'b000001;
        tick();
        bus.src_viol = '0;
        tick();
        chk("s6_pre_reset", {63'd0, bus.reset}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("s6_async_reset", {63'd0, bus.reset}, 64'd0);
        chk("s6_async_count", {61'd0, bus.log_count}, 64'd0);
        reset_n = 1'b1;
        bus.src_viol = 6'b000001;
        tick();
        bus.src_viol = '0;
        chk("s6_idle_detect", {63'd0, bus.reset}, 64'd1);
        chk("s6_idle_count", {61'd0, bus.log_count}, 64'd1);
        run_out(hi);
        chk("s6_reset_len", hi, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
